multicycle_control_fsm: RTL and testbench

- Multi-cycle RV32I control unit. Sequences one instruction at a time through FETCH/DECODE/EXECUTE/MEM/WRITEBACK over a shared ALU and a single memory port.
- Sits in the decode stage and drives the multi-cycle datapath: PC, IR, OldPC, A/B, ALUOut and Data registers, all of which latch in the datapath.
- Adds over the single-cycle unit: a memory ready handshake with a watchdog, beq/sub/slt/lw/sw support, illegal-instruction trapping, and a retire strobe.

---
 rtl/multicycle_control_fsm.sv | 237 +++++++++++++++++++++++
 tb/tb_multicycle_control_fsm.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control_fsm.sv
// Multi-cycle RV32I control FSM: FETCH/DECODE/EXECUTE/MEM/WB over one ALU and one memory port.
// 3-5 cycles per instruction; FETCH/MEMREAD/MEMWRITE stall on mem_ready, with a watchdog into ERROR.
module multicycle_control_fsm #(
  parameter int TIMEOUT_CYCLES = 15,
  parameter int CNT_W          = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] Instr,
  input  logic        EQ,
  input  logic        mem_ready,
  output logic        PCWrite,
  output logic        IRWrite,
  output logic        AdrSrc,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        RegWrite,
  output logic [1:0]  ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [3:0]  ALUctrl,
  output logic [2:0]  ImmSrc,
  output logic [1:0]  ResultSrc,
  output logic        instr_retired,
  output logic        illegal,
  output logic        timeout,
  output logic [3:0]  state
);

  localparam logic [3:0] ALU_OPCODE_ADD = 4'd0;
  localparam logic [3:0] ALU_OPCODE_SUB = 4'd1;
  localparam logic [3:0] ALU_OPCODE_AND = 4'd2;
  localparam logic [3:0] ALU_OPCODE_OR  = 4'd3;
  localparam logic [3:0] ALU_OPCODE_SLT = 4'd4;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECR    = 4'd6,
    EXECI    = 4'd7,
    EXECU    = 4'd8,
    ALUWB    = 4'd9,
    BRANCH   = 4'd10,
    JAL      = 4'd11,
    JALR1    = 4'd12,
    JALR2    = 4'd13,
    ERROR    = 4'd15
  } state_t;

  state_t           cur_state, nxt_state;
  logic [CNT_W-1:0] wd_cnt;
  logic             illegal_q, timeout_q;
  logic             set_illegal, set_timeout;
  logic             waiting, expire, r_legal;
  logic [6:0]       op, funct7;
  logic [2:0]       funct3;
  logic             unused_instr;

  assign op           = Instr[6:0];
  assign funct3       = Instr[14:12];
  assign funct7       = Instr[31:25];
  assign unused_instr = ^{Instr[24:15], Instr[11:7]};

  assign waiting = (cur_state == FETCH) || (cur_state == MEMREAD) || (cur_state == MEMWRITE);
  // A response arriving in the expiry cycle still wins because expire requires mem_ready low.
  assign expire  = waiting && !mem_ready && (wd_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  assign r_legal = ((funct7 == 7'h00) && (funct3 inside {3'b000, 3'b111, 3'b110, 3'b010})) ||
                   ((funct7 == 7'h20) && (funct3 == 3'b000));

  assign state   = cur_state;
  assign illegal = illegal_q;
  assign timeout = timeout_q;

  function automatic logic [3:0] alu_from_f3(input logic [2:0] f3, input logic sub);
    case (f3)
      3'b000:  alu_from_f3 = sub ? ALU_OPCODE_SUB : ALU_OPCODE_ADD;
      3'b111:  alu_from_f3 = ALU_OPCODE_AND;
      3'b110:  alu_from_f3 = ALU_OPCODE_OR;
      3'b010:  alu_from_f3 = ALU_OPCODE_SLT;
      default: alu_from_f3 = ALU_OPCODE_ADD;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      cur_state <= FETCH;
      wd_cnt    <= '0;
      illegal_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      cur_state <= nxt_state;
      wd_cnt    <= (waiting && !mem_ready) ? wd_cnt + CNT_W'(1) : '0;
      if (set_illegal) illegal_q <= 1'b1;
      if (set_timeout) timeout_q <= 1'b1;
    end
  end

  always_comb begin
    nxt_state     = cur_state;
    set_illegal   = 1'b0;
    set_timeout   = 1'b0;
    PCWrite       = 1'b0;
    IRWrite       = 1'b0;
    AdrSrc        = 1'b0;
    MemRead       = 1'b0;
    MemWrite      = 1'b0;
    RegWrite      = 1'b0;
    ALUSrcA       = 2'b00;
    ALUSrcB       = 2'b00;
    ALUctrl       = ALU_OPCODE_ADD;
    ImmSrc        = 3'b000;
    ResultSrc     = 2'b00;
    instr_retired = 1'b0;

    case (cur_state)
      FETCH: begin
        MemRead   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        IRWrite   = mem_ready;
        PCWrite   = mem_ready;
        if (mem_ready) nxt_state = DECODE;
      end
      DECODE: begin
        // Branch target is precomputed here into ALUOut.
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        ImmSrc  = 3'b010;
        case (op)
          7'b0000011: nxt_state = (funct3 inside {3'b100, 3'b010}) ? MEMADR : ERROR;
          7'b0100011: nxt_state = (funct3 inside {3'b000, 3'b010}) ? MEMADR : ERROR;
          7'b0110011: nxt_state = r_legal ? EXECR : ERROR;
          7'b0010011: nxt_state = (funct3 inside {3'b000, 3'b111, 3'b110, 3'b010}) ? EXECI : ERROR;
          7'b0010111: nxt_state = EXECU;
          7'b1100011: nxt_state = (funct3 inside {3'b000, 3'b001}) ? BRANCH : ERROR;
          7'b1101111: nxt_state = JAL;
          7'b1100111: nxt_state = (funct3 == 3'b000) ? JALR1 : ERROR;
          default:    nxt_state = ERROR;
        endcase
        set_illegal = (nxt_state == ERROR);
      end
      MEMADR: begin
        ALUSrcA   = 2'b10;
        ALUSrcB   = 2'b01;
        ImmSrc    = op[5] ? 3'b001 : 3'b000;
        nxt_state = op[5] ? MEMWRITE : MEMREAD;
      end
      MEMREAD: begin
        MemRead = 1'b1;
        AdrSrc  = 1'b1;
        if (mem_ready) nxt_state = MEMWB;
      end
      MEMWB: begin
        ResultSrc     = 2'b01;
        RegWrite      = 1'b1;
        instr_retired = 1'b1;
        nxt_state     = FETCH;
      end
      MEMWRITE: begin
        MemWrite = 1'b1;
        AdrSrc   = 1'b1;
        if (mem_ready) begin
          instr_retired = 1'b1;
          nxt_state     = FETCH;
        end
      end
      EXECR: begin
        ALUSrcA   = 2'b10;
        ALUctrl   = alu_from_f3(funct3, funct7[5]);
        nxt_state = ALUWB;
      end
      EXECI: begin
        ALUSrcA   = 2'b10;
        ALUSrcB   = 2'b01;
        ALUctrl   = alu_from_f3(funct3, 1'b0);
        nxt_state = ALUWB;
      end
      EXECU: begin
        ALUSrcA   = 2'b01;
        ALUSrcB   = 2'b01;
        ImmSrc    = 3'b011;
        nxt_state = ALUWB;
      end
      ALUWB: begin
        RegWrite      = 1'b1;
        instr_retired = 1'b1;
        nxt_state     = FETCH;
      end
      BRANCH: begin
        ALUSrcA       = 2'b10;
        ALUctrl       = ALU_OPCODE_SUB;
        PCWrite       = funct3[0] ? ~EQ : EQ;
        instr_retired = 1'b1;
        nxt_state     = FETCH;
      end
      JAL: begin
        ALUSrcA   = 2'b01;
        ALUSrcB   = 2'b10;
        ImmSrc    = 3'b100;
        PCWrite   = 1'b1;
        nxt_state = ALUWB;
      end
      JALR1: begin
        ALUSrcA   = 2'b10;
        ALUSrcB   = 2'b01;
        nxt_state = JALR2;
      end
      JALR2: begin
        ALUSrcA   = 2'b01;
        ALUSrcB   = 2'b10;
        PCWrite   = 1'b1;
        nxt_state = ALUWB;
      end
      ERROR:   nxt_state = ERROR;
      default: nxt_state = ERROR;
    endcase

    if (expire) begin
      nxt_state   = ERROR;
      set_timeout = 1'b1;
    end

    if (rst) begin
      PCWrite       = 1'b0;
      IRWrite       = 1'b0;
      MemRead       = 1'b0;
      MemWrite      = 1'b0;
      RegWrite      = 1'b0;
      instr_retired = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed bench for multicycle_control_fsm: expected per-cycle outputs are queued by the
// stimulus and compared by an independent monitor on the falling edge.
module tb_multicycle_control_fsm;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] Instr = 32'h0;
  logic        EQ = 1'b0;
  logic        mem_ready = 1'b0;
  logic        PCWrite, IRWrite, AdrSrc, MemRead, MemWrite, RegWrite;
  logic [1:0]  ALUSrcA, ALUSrcB, ResultSrc;
  logic [3:0]  ALUctrl, state;
  logic [2:0]  ImmSrc;
  logic        instr_retired, illegal, timeout;

  always #5 clk = ~clk;

  multicycle_control_fsm #(.TIMEOUT_CYCLES(4), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .Instr(Instr), .EQ(EQ), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .IRWrite(IRWrite), .AdrSrc(AdrSrc), .MemRead(MemRead),
    .MemWrite(MemWrite), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ALUctrl(ALUctrl), .ImmSrc(ImmSrc), .ResultSrc(ResultSrc),
    .instr_retired(instr_retired), .illegal(illegal), .timeout(timeout), .state(state)
  );

  typedef struct packed {
    logic [3:0] st;
    logic       pcw, irw, adr, mrd, mwr, rgw;
    logic [1:0] sa, sb;
    logic [3:0] alu;
    logic [2:0] imm;
    logic [1:0] res;
    logic       ret, ill, tmo;
  } obs_t;

  localparam logic [3:0] S_FETCH = 4'd0, S_DECODE = 4'd1, S_MEMADR = 4'd2, S_MEMREAD = 4'd3,
                         S_MEMWB = 4'd4, S_MEMWRITE = 4'd5, S_EXECR = 4'd6, S_EXECI = 4'd7,
                         S_EXECU = 4'd8, S_ALUWB = 4'd9, S_BRANCH = 4'd10, S_JALR1 = 4'd12,
                         S_JALR2 = 4'd13, S_ERROR = 4'd15;
  localparam logic [3:0] A_ADD = 4'd0, A_SUB = 4'd1, A_AND = 4'd2, A_OR = 4'd3;

  localparam logic [31:0] I_ADDI  = 32'h00500093;  // addi x1,x0,5
  localparam logic [31:0] I_LW    = 32'h0000A103;  // lw   x2,0(x1)
  localparam logic [31:0] I_BNE   = 32'h00209463;  // bne  x1,x2,8
  localparam logic [31:0] I_SUB   = 32'h402081B3;  // sub  x3,x1,x2
  localparam logic [31:0] I_AND   = 32'h0020F233;  // and  x4,x1,x2
  localparam logic [31:0] I_ORI   = 32'h0030E093;  // ori  x1,x1,3
  localparam logic [31:0] I_AUIPC = 32'h00001097;  // auipc x1,1
  localparam logic [31:0] I_JALR  = 32'h000280E7;  // jalr x1,0(x5)
  localparam logic [31:0] I_SW    = 32'h0020A223;  // sw   x2,4(x1)
  localparam logic [31:0] I_LUI   = 32'h000010B7;  // lui  x1,1 (unsupported)

  obs_t  exp_q[$];
  string name_q[$];
  int    checks = 0;
  int    errors = 0;
  logic  exp_ill = 1'b0;
  logic  exp_tmo = 1'b0;

  // Expected outputs per state, hand-written from the control table; the few
  // input-dependent fields come in as arguments.
  function automatic obs_t ex(input logic [3:0] st, input logic pcw = 1'b0, input logic irw = 1'b0,
                              input logic [3:0] alu = A_ADD, input logic [2:0] imm = 3'b000,
                              input logic ret = 1'b0);
    obs_t e;
    e = '0;
    e.st  = st;
    e.ill = exp_ill;
    e.tmo = exp_tmo;
    case (st)
      S_FETCH:    begin e.mrd = 1; e.sb = 2'b10; e.res = 2'b10; e.pcw = pcw; e.irw = irw; end
      S_DECODE:   begin e.sa = 2'b01; e.sb = 2'b01; e.imm = 3'b010; end
      S_MEMADR:   begin e.sa = 2'b10; e.sb = 2'b01; e.imm = imm; end
      S_MEMREAD:  begin e.mrd = 1; e.adr = 1; end
      S_MEMWB:    begin e.res = 2'b01; e.rgw = 1; e.ret = 1; end
      S_MEMWRITE: begin e.mwr = 1; e.adr = 1; e.ret = ret; end
      S_EXECR:    begin e.sa = 2'b10; e.alu = alu; end
      S_EXECI:    begin e.sa = 2'b10; e.sb = 2'b01; e.alu = alu; end
      S_EXECU:    begin e.sa = 2'b01; e.sb = 2'b01; e.imm = 3'b011; end
      S_ALUWB:    begin e.rgw = 1; e.ret = 1; end
      S_BRANCH:   begin e.sa = 2'b10; e.alu = A_SUB; e.pcw = pcw; e.ret = 1; end
      S_JALR1:    begin e.sa = 2'b10; e.sb = 2'b01; end
      S_JALR2:    begin e.sa = 2'b01; e.sb = 2'b10; e.pcw = 1; end
      default:    ;
    endcase
    return e;
  endfunction

  task automatic step(input string nm, input logic r, input logic [31:0] ins,
                      input logic mr, input logic eq, input obs_t e);
    @(posedge clk);
    #1;
    rst       = r;
    Instr     = ins;
    mem_ready = mr;
    EQ        = eq;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  initial begin : monitor
    obs_t  a, e;
    string nm;
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        a  = {state, PCWrite, IRWrite, AdrSrc, MemRead, MemWrite, RegWrite, ALUSrcA, ALUSrcB,
              ALUctrl, ImmSrc, ResultSrc, instr_retired, illegal, timeout};
        checks++;
        if (a !== e) begin
          errors++;
          $display("FAIL %s got %h expected %h", nm, a, e);
        end
      end
    end
  end

  initial begin : stim
    obs_t e;
    @(posedge clk);
    // Held in reset: FETCH with every enable suppressed even though mem_ready is high.
    e = ex(S_FETCH); e.mrd = 1'b0;
    step("reset", 1, I_ADDI, 1, 0, e);

    step("addi_fetch",  0, I_ADDI, 1, 0, ex(S_FETCH, 1, 1));
    step("addi_decode", 0, I_ADDI, 1, 0, ex(S_DECODE));
    step("addi_execi",  0, I_ADDI, 1, 0, ex(S_EXECI, 0, 0, A_ADD));
    step("addi_aluwb",  0, I_ADDI, 1, 0, ex(S_ALUWB));

    step("lw_fetch",   0, I_LW, 1, 0, ex(S_FETCH, 1, 1));
    step("lw_decode",  0, I_LW, 1, 0, ex(S_DECODE));
    step("lw_memadr",  0, I_LW, 1, 0, ex(S_MEMADR, 0, 0, A_ADD, 3'b000));
    for (int i = 0; i < 3; i++)
      step("lw_memread_wait", 0, I_LW, 0, 0, ex(S_MEMREAD));
    step("lw_memread_expiry_ready", 0, I_LW, 1, 0, ex(S_MEMREAD));
    step("lw_memwb",   0, I_LW, 1, 0, ex(S_MEMWB));

    step("bne_eq_fetch",  0, I_BNE, 1, 1, ex(S_FETCH, 1, 1));
    step("bne_eq_decode", 0, I_BNE, 1, 1, ex(S_DECODE));
    step("bne_eq_branch", 0, I_BNE, 1, 1, ex(S_BRANCH, 0));
    step("bne_ne_fetch",  0, I_BNE, 1, 0, ex(S_FETCH, 1, 1));
    step("bne_ne_decode", 0, I_BNE, 1, 0, ex(S_DECODE));
    step("bne_ne_branch", 0, I_BNE, 1, 0, ex(S_BRANCH, 1));

    step("sub_fetch",  0, I_SUB, 1, 0, ex(S_FETCH, 1, 1));
    step("sub_decode", 0, I_SUB, 1, 0, ex(S_DECODE));
    step("sub_execr",  0, I_SUB, 1, 0, ex(S_EXECR, 0, 0, A_SUB));
    step("sub_aluwb",  0, I_SUB, 1, 0, ex(S_ALUWB));

    step("and_fetch",  0, I_AND, 1, 0, ex(S_FETCH, 1, 1));
    step("and_decode", 0, I_AND, 1, 0, ex(S_DECODE));
    step("and_execr",  0, I_AND, 1, 0, ex(S_EXECR, 0, 0, A_AND));
    step("and_aluwb",  0, I_AND, 1, 0, ex(S_ALUWB));

    step("ori_fetch",  0, I_ORI, 1, 0, ex(S_FETCH, 1, 1));
    step("ori_decode", 0, I_ORI, 1, 0, ex(S_DECODE));
    step("ori_execi",  0, I_ORI, 1, 0, ex(S_EXECI, 0, 0, A_OR));
    step("ori_aluwb",  0, I_ORI, 1, 0, ex(S_ALUWB));

    step("auipc_fetch",  0, I_AUIPC, 1, 0, ex(S_FETCH, 1, 1));
    step("auipc_decode", 0, I_AUIPC, 1, 0, ex(S_DECODE));
    step("auipc_execu",  0, I_AUIPC, 1, 0, ex(S_EXECU));
    step("auipc_aluwb",  0, I_AUIPC, 1, 0, ex(S_ALUWB));

    step("jalr_fetch",  0, I_JALR, 1, 0, ex(S_FETCH, 1, 1));
    step("jalr_decode", 0, I_JALR, 1, 0, ex(S_DECODE));
    step("jalr_jalr1",  0, I_JALR, 1, 0, ex(S_JALR1));
    step("jalr_jalr2",  0, I_JALR, 1, 0, ex(S_JALR2));
    step("jalr_aluwb",  0, I_JALR, 1, 0, ex(S_ALUWB));

    step("sw_fetch",      0, I_SW, 1, 0, ex(S_FETCH, 1, 1));
    step("sw_decode",     0, I_SW, 1, 0, ex(S_DECODE));
    step("sw_memadr",     0, I_SW, 1, 0, ex(S_MEMADR, 0, 0, A_ADD, 3'b001));
    step("sw_write_wait", 0, I_SW, 0, 0, ex(S_MEMWRITE, 0, 0, A_ADD, 3'b000, 0));
    step("sw_write_done", 0, I_SW, 1, 0, ex(S_MEMWRITE, 0, 0, A_ADD, 3'b000, 1));

    step("lui_fetch",  0, I_LUI, 1, 0, ex(S_FETCH, 1, 1));
    step("lui_decode", 0, I_LUI, 1, 0, ex(S_DECODE));
    exp_ill = 1'b1;
    for (int i = 0; i < 20; i++)
      step("lui_error_hold", 0, I_LUI, 1, i[0], ex(S_ERROR));
    step("error_in_reset", 1, I_ADDI, 0, 0, ex(S_ERROR));
    exp_ill = 1'b0;

    for (int i = 0; i < 4; i++)
      step("fetch_wait", 0, I_ADDI, 0, 0, ex(S_FETCH, 0, 0));
    exp_tmo = 1'b1;
    step("timeout_error", 0, I_ADDI, 0, 0, ex(S_ERROR));
    step("timeout_sticky", 0, I_ADDI, 1, 0, ex(S_ERROR));
    step("timeout_in_reset", 1, I_ADDI, 1, 0, ex(S_ERROR));
    exp_tmo = 1'b0;
    step("post_reset_fetch",  0, I_ADDI, 1, 0, ex(S_FETCH, 1, 1));
    step("post_reset_decode", 0, I_ADDI, 1, 0, ex(S_DECODE));

    repeat (3) @(negedge clk);
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d pending expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin : guard
    #200000;
    $display("FAIL sim_time_limit got running expected finished");
    $fatal(1, "time limit");
  end

endmodule
